decoder_pulse_n: RTL and testbench
==================================

# decoder_pulse_n

Parametrised, registered binary-to-M-line decoder with a valid/ready input handshake, selectable decode mode (one-hot, thermometer, accumulate) and a programmable output pulse length. It extends the combinational 3-to-8 one-hot decoder into a clocked block. Typical uses are strobe generation, row/bank enables and per-channel event flags, with upstream logic driving it through a standard handshake.

## Interface
- N, default 3: select width; number of output lines M = 2**N (localparam, derived).
- LEN_W, default 4: width of pulse-length field.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept this cycle.
- in_sel  in  N  line index to decode.
- in_mode  in  2  00 one-hot, 01 thermometer, 10 accumulate, 11 treated as 00.
- in_len  in  LEN_W  pulse length minus one (output asserted in_len+1 cycles).
- clr  in  1  synchronous clear of accumulator.
- out_valid  out  1  decoded value being driven.
- out_y  out  M  decoded lines; all zero when out_valid=0.
- acc  out  M  accumulator contents.
- busy  out  1  FSM in DRIVE.

## Operation
- Accept = in_valid & in_ready. On accept, in_sel, in_mode and in_len are captured; the inputs may then change freely.
- Decode of sel s:
  - one-hot: bit s only.
  - thermometer: bits 0..s set (s=M-1 gives all ones).
  - accumulate: acc | (1<<s). The same value is written back into acc on accept.
- FSM states:
  - IDLE: in_ready=1, out_valid=0, out_y=0. Accept -> DRIVE with cnt=in_len.
  - DRIVE: out_valid=1, out_y holds the captured decode. cnt decrements each cycle.
  - At cnt==0, in_ready=1. Accept in that cycle reloads from the new request and stays in DRIVE, giving back-to-back pulses with no gap. Otherwise DRIVE -> IDLE.
- in_ready=0 in DRIVE while cnt!=0. in_valid is ignored in those cycles (no back-pressure loss; upstream holds).
- clr:
  - acc <= 0 next edge.
  - clr together with an accumulate accept in the same cycle gives acc = 1<<s (clear first, then set); out_y shows 1<<s.
  - clr does not affect an in-flight pulse's out_y.
- acc changes only on accumulate accept, clr or rst. It is untouched by one-hot and thermometer accepts.
- Reset values: state IDLE, cnt=0, out_valid=0, out_y=0, acc=0, busy=0. in_ready is 1 in the cycle after rst deasserts.
- rst asserted mid-pulse terminates the pulse at the next edge. rst has priority over accept and clr.

## Timing
- Latency: accept at edge k -> out_valid/out_y valid from k through the cycle before edge k+in_len+1, i.e. exactly in_len+1 cycles.
- All outputs are registered except in_ready, which is combinational from state and cnt only (no path from in_valid).
- Back-to-back at cnt==0: out_valid stays 1 continuously, and out_y switches at the reload edge.
- in_len=0: single-cycle pulse. With a continuous stream at in_len=0, in_ready stays 1 and throughput is one request per cycle.
- Maximum pulse is 2**LEN_W cycles. cnt is LEN_W bits and never wraps (the reload happens at 0).

## Structure
- Shared package decoder_pkg holds:
  - mode enum: MODE_ONEHOT=2'b00, MODE_THERM=2'b01, MODE_ACC=2'b10.
  - FSM state enum: IDLE, DRIVE.
- One sub-module, decoder_comb_n: pure combinational N-to-M decode with mode and acc inputs, reused by other blocks. The top holds the FSM, counter and registers.

## Test plan
- Reset, then one-hot, sel=5, len=0 (N=3) -> out_y=8'b0010_0000 for exactly 1 cycle starting the edge after accept; then out_y=0 and in_ready=1.
- Thermometer, sel=3, len=2 -> out_y=8'b0000_1111 for 3 cycles; in_ready low for the first 2 of them and high on the last.
- Accumulate sel=1, then sel=6 (each len=0), then one-hot sel=0 -> acc=8'h02, then 8'h42, unchanged after the one-hot; out_y shows 8'h02, 8'h42, 8'h01.
- clr together with accumulate sel=4 while acc=8'hFF -> acc=8'h10 and out_y=8'h10.
- Back-to-back: len=1 pulses with in_valid held, sel 2 then 7 -> out_valid continuously high for 4 cycles, out_y 8'h04,8'h04,8'h80,8'h80.
- rst asserted in the 2nd cycle of a len=5 pulse with acc=8'h0F -> next cycle out_valid=0, out_y=0, acc=0, busy=0, in_ready=1 after rst drops.

Source files
------------

// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared types for the decoder family.
//   mode_e  : decode mode carried on in_mode (2'b11 is decoded as one-hot).
//   state_e : pulse FSM states of decoder_pulse_n.
// -----------------------------------------------------------------------------
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_THERM  = 2'b01,
    MODE_ACC    = 2'b10
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

endpackage : decoder_pkg

// File: rtl/decoder_comb_n.sv
// -----------------------------------------------------------------------------
// decoder_comb_n
// Pure combinational N-to-M decoder (M = 2**N) with selectable mode.
// Ports:
//   sel_i  [N-1:0] line index
//   mode_i [1:0]   00 one-hot, 01 thermometer, 10 accumulate, 11 one-hot
//   acc_i  [M-1:0] accumulator value OR-ed in for accumulate mode
//   y_o    [M-1:0] decoded lines
// -----------------------------------------------------------------------------
module decoder_comb_n
  import decoder_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]    sel_i,
  input  logic [1:0]      mode_i,
  input  logic [2**N-1:0] acc_i,
  output logic [2**N-1:0] y_o
);

  localparam int M = 2**N;

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves it unassigned would infer a latch.
  always_comb begin
    y_o = '0;
    case (mode_i)
      MODE_THERM: begin
        // Bits 0..sel set; sel = M-1 yields all ones without overflow.
        for (int i = 0; i < M; i++) begin
          y_o[i] = (i <= int'(sel_i));
        end
      end
      MODE_ACC: y_o = acc_i | (M'(1) << sel_i);
      default:  y_o[sel_i] = 1'b1;
    endcase
  end

endmodule : decoder_comb_n

// File: rtl/decoder_pulse_n.sv
// -----------------------------------------------------------------------------
// decoder_pulse_n
// Registered binary-to-M-line decoder with valid/ready input, selectable decode
// mode and programmable pulse length (in_len+1 cycles).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready request handshake (in_ready depends on state/cnt only)
//   in_sel  [N-1:0]   line index
//   in_mode [1:0]     00 one-hot, 01 thermometer, 10 accumulate, 11 one-hot
//   in_len  [LEN_W-1:0] pulse length minus one
//   clr               synchronous accumulator clear
//   out_valid         decoded value being driven
//   out_y   [M-1:0]   decoded lines, zero when out_valid=0
//   acc     [M-1:0]   accumulator contents
//   busy              FSM in DRIVE
// -----------------------------------------------------------------------------
module decoder_pulse_n
  import decoder_pkg::*;
#(
  parameter int N     = 3,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_sel,
  input  logic [1:0]       in_mode,
  input  logic [LEN_W-1:0] in_len,
  input  logic             clr,
  output logic             out_valid,
  output logic [2**N-1:0]  out_y,
  output logic [2**N-1:0]  acc,
  output logic             busy
);

  localparam int M = 2**N;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [M-1:0]     y_q, y_d;
  logic [M-1:0]     acc_q, acc_d;

  logic             accept;
  logic [M-1:0]     acc_base;
  logic [M-1:0]     dec_y;

  // A pulse may be replaced on its last cycle, so ready is high in IDLE and
  // whenever the counter has reached zero.
  assign in_ready = (state_q == IDLE) || (cnt_q == '0);
  assign accept   = in_valid && in_ready;

  // clr takes effect before an accumulate in the same cycle: clear, then set.
  assign acc_base = clr ? '0 : acc_q;

  decoder_comb_n #(.N(N)) u_comb (
    .sel_i  (in_sel),
    .mode_i (in_mode),
    .acc_i  (acc_base),
    .y_o    (dec_y)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    acc_d   = acc_q;

    if (clr) acc_d = '0;

    if (accept) begin
      state_d = DRIVE;
      cnt_d   = in_len;
      y_d     = dec_y;
      if (in_mode == MODE_ACC) acc_d = dec_y;
    end else if (state_q == DRIVE) begin
      if (cnt_q == '0) begin
        state_d = IDLE;
        y_d     = '0;
      end else begin
        cnt_d = cnt_q - LEN_W'(1);
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
    end
  end

  assign out_valid = (state_q == DRIVE);
  assign busy      = (state_q == DRIVE);
  assign out_y     = y_q;
  assign acc       = acc_q;

endmodule : decoder_pulse_n

// File: tb/tb_decoder_pulse_n.sv
// -----------------------------------------------------------------------------
// tb_decoder_pulse_n
// Directed, table-driven bench for decoder_pulse_n (N=3, LEN_W=4). Each record
// holds the inputs driven for one cycle and the outputs expected just after
// the following rising edge.
// -----------------------------------------------------------------------------
module tb_decoder_pulse_n;

  localparam int N     = 3;
  localparam int LEN_W = 4;
  localparam int M     = 2**N;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_sel;
  logic [1:0]       in_mode;
  logic [LEN_W-1:0] in_len;
  logic             clr;
  logic             out_valid;
  logic [M-1:0]     out_y;
  logic [M-1:0]     acc;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decoder_pulse_n #(.N(N), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_mode   (in_mode),
    .in_len    (in_len),
    .clr       (clr),
    .out_valid (out_valid),
    .out_y     (out_y),
    .acc       (acc),
    .busy      (busy)
  );

  typedef struct {
    string            name;
    logic             rst;
    logic             v;
    logic [N-1:0]     sel;
    logic [1:0]       mode;
    logic [LEN_W-1:0] len;
    logic             clr;
    logic             rdy;
    logic             ov;
    logic [M-1:0]     y;
    logic [M-1:0]     acc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic r, logic v, int sel, int mode,
                              int len, logic c, logic rdy, logic ov, int y, int a);
    vec_t t;
    t.name = name; t.rst = r; t.v = v;
    t.sel  = N'(sel); t.mode = 2'(mode); t.len = LEN_W'(len); t.clr = c;
    t.rdy  = rdy; t.ov = ov; t.y = M'(y); t.acc = M'(a);
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Drive one record at the falling edge, sample #1 after the rising edge.
  task automatic apply(input vec_t t);
    @(negedge clk);
    rst = t.rst; in_valid = t.v; in_sel = t.sel; in_mode = t.mode;
    in_len = t.len; clr = t.clr;
    @(posedge clk);
    #1;
    check({t.name, ".in_ready"},  32'(in_ready),  32'(t.rdy));
    check({t.name, ".out_valid"}, 32'(out_valid), 32'(t.ov));
    check({t.name, ".busy"},      32'(busy),      32'(t.ov));
    check({t.name, ".out_y"},     32'(out_y),     32'(t.y));
    check({t.name, ".acc"},       32'(acc),       32'(t.acc));
  endtask

  initial begin
    logic [M-1:0] a_exp;
    int           cycles;

    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_mode = '0; in_len = '0; clr = 1'b0;

    //             name        rst v sel mode len clr  rdy ov  y     acc
    vecs.push_back(mk("reset",   1, 0, 0, 0, 0, 0,  1, 0, 'h00, 'h00));
    vecs.push_back(mk("idle",    0, 0, 0, 0, 0, 0,  1, 0, 'h00, 'h00));
    vecs.push_back(mk("oh5",     0, 1, 5, 0, 0, 0,  1, 1, 'h20, 'h00));
    vecs.push_back(mk("oh5_end", 0, 0, 0, 0, 0, 0,  1, 0, 'h00, 'h00));
    vecs.push_back(mk("th3_c1",  0, 1, 3, 1, 2, 0,  0, 1, 'h0F, 'h00));
    vecs.push_back(mk("th3_c2",  0, 1, 7, 0, 0, 0,  0, 1, 'h0F, 'h00)); // ignored request
    vecs.push_back(mk("th3_c3",  0, 0, 0, 0, 0, 0,  1, 1, 'h0F, 'h00));
    vecs.push_back(mk("th3_end", 0, 0, 0, 0, 0, 0,  1, 0, 'h00, 'h00));
    vecs.push_back(mk("acc1",    0, 1, 1, 2, 0, 0,  1, 1, 'h02, 'h02));
    vecs.push_back(mk("acc6",    0, 1, 6, 2, 0, 0,  1, 1, 'h42, 'h42));
    vecs.push_back(mk("oh0",     0, 1, 0, 0, 0, 0,  1, 1, 'h01, 'h42));
    vecs.push_back(mk("oh0_end", 0, 0, 0, 0, 0, 0,  1, 0, 'h00, 'h42));
    vecs.push_back(mk("clr",     0, 0, 0, 0, 0, 1,  1, 0, 'h00, 'h00));
    a_exp = '0;
    for (int i = 0; i < M; i++) begin
      a_exp = a_exp | (M'(1) << i);
      vecs.push_back(mk($sformatf("fill%0d", i), 0, 1, i, 2, 0, 0, 1, 1, int'(a_exp), int'(a_exp)));
    end
    vecs.push_back(mk("clr_acc4", 0, 1, 4, 2, 0, 1,  1, 1, 'h10, 'h10));
    vecs.push_back(mk("ca4_end",  0, 0, 0, 0, 0, 0,  1, 0, 'h00, 'h10));
    vecs.push_back(mk("th7_c1",   0, 1, 7, 1, 1, 0,  0, 1, 'hFF, 'h10));
    vecs.push_back(mk("clr_fly",  0, 0, 0, 0, 0, 1,  1, 1, 'hFF, 'h00));
    vecs.push_back(mk("th7_end",  0, 0, 0, 0, 0, 0,  1, 0, 'h00, 'h00));
    vecs.push_back(mk("mode11",   0, 1, 2, 3, 0, 0,  1, 1, 'h04, 'h00));
    vecs.push_back(mk("m11_end",  0, 0, 0, 0, 0, 0,  1, 0, 'h00, 'h00));

    foreach (vecs[i]) apply(vecs[i]);

    // Back-to-back len=1 pulses with in_valid held: no gap at the reload.
    apply(mk("b2b_c1",  0, 1, 2, 0, 1, 0,  0, 1, 'h04, 'h00));
    apply(mk("b2b_c2",  0, 1, 7, 0, 1, 0,  1, 1, 'h04, 'h00));
    apply(mk("b2b_c3",  0, 1, 7, 0, 1, 0,  0, 1, 'h80, 'h00));
    apply(mk("b2b_c4",  0, 0, 0, 0, 0, 0,  1, 1, 'h80, 'h00));
    apply(mk("b2b_end", 0, 0, 0, 0, 0, 0,  1, 0, 'h00, 'h00));

    // Maximum length pulse: in_len = 2**LEN_W-1 gives 2**LEN_W cycles.
    apply(mk("max_c1",  0, 1, 3, 0, 15, 0, 0, 1, 'h08, 'h00));
    @(negedge clk);
    in_valid = 1'b0;
    cycles = 1;
    while (out_valid && cycles < 40) begin
      @(posedge clk);
      #1;
      if (out_valid) cycles++;
    end
    check("max_len_cycles", 32'(cycles), 32'(2**LEN_W));

    // Reset in the second cycle of a len=5 pulse, with acc = 8'h0F.
    for (int i = 0; i < 4; i++) begin
      a_exp = M'((1 << (i + 1)) - 1);
      apply(mk($sformatf("pre%0d", i), 0, 1, i, 2, 0, 0, 1, 1, int'(a_exp), int'(a_exp)));
    end
    apply(mk("pre_end",   0, 0, 0, 0, 0, 0,  1, 0, 'h00, 'h0F));
    apply(mk("rst_c1",    0, 1, 1, 0, 5, 0,  0, 1, 'h02, 'h0F));
    apply(mk("rst_c2",    0, 0, 0, 0, 0, 0,  0, 1, 'h02, 'h0F));
    apply(mk("rst_hit",   1, 1, 6, 2, 0, 1,  1, 0, 'h00, 'h00));
    apply(mk("rst_after", 0, 0, 0, 0, 0, 0,  1, 0, 'h00, 'h00));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_decoder_pulse_n
